// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I multicycle controller and the
// single-cycle immediate decoder.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format select; also used by the single-cycle path.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [2:0] o_imm_src
);

    // Pure opcode decode, independent of controller state
    always_comb begin
        o_imm_src = IMM_I;
        case (i_op)
            OP_SW:             o_imm_src = IMM_S;
            OP_BEQ:            o_imm_src = IMM_B;
            OP_JAL:            o_imm_src = IMM_J;
            OP_LUI, OP_AUIPC:  o_imm_src = IMM_U;
            default:           o_imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle RV32I main controller: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects/enables.
//
// state    | meaning
// FETCH    | read instruction, PC+4 (waits on memory)
// DECODE   | register read, OldPC+imm precomputed for branches
// MEMADR   | load/store address = rs1 + imm
// MEMREAD  | data read (waits on memory)
// MEMWB    | load data to register file
// MEMWRITE | data write (waits on memory)
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// ALUWB    | ALUOut to register file
// BEQ      | compare, conditional PC write
// JAL      | PC <- target, compute link
// JALR     | target = rs1 + imm
// JALR2    | PC <- target, compute link
// LUI      | 0 + U-immediate
// AUIPC    | OldPC + U-immediate
// TRAP     | illegal opcode, frozen until reset
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT = 1'b1,
    parameter bit EN_JALR  = 1'b1,
    parameter bit EN_UPPER = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_update,
    output logic       branch,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_ready;
    logic   w_mem_req, w_pc_update, w_branch, w_ir_write, w_reg_write, w_mem_write;

    assign w_ready = MEM_WAIT ? mem_ready : 1'b1;

    // State register; reset aborts whatever instruction is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Sticky trap flag, raised on the edge that enters TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_illegal <= 1'b0;
        else if (w_next == S_TRAP) r_illegal <= 1'b1;
    end

    // Next-state sequencing
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTER;
                    OP_ITYPE:     w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    OP_JALR:      w_next = EN_JALR  ? S_JALR  : S_TRAP;
                    OP_LUI:       w_next = EN_UPPER ? S_LUI   : S_TRAP;
                    OP_AUIPC:     w_next = EN_UPPER ? S_AUIPC : S_TRAP;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = S_JALR2;
            S_JALR2:    w_next = S_ALUWB;
            S_LUI:      w_next = S_ALUWB;
            S_AUIPC:    w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; unused selects stay 0
    always_comb begin
        w_mem_req   = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        result_src  = RES_ALUOUT;
        alu_op      = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_ir_write  = w_ready;
                w_pc_update = w_ready;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                adr_src   = 1'b1;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                adr_src     = 1'b1;
                w_mem_write = w_ready;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                w_branch  = 1'b1;
            end
            S_JAL, S_JALR2: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            default: ;
        endcase
    end

    // Enables are held off for the whole reset window, not just until the edge
    assign mem_req       = w_mem_req   & rst_n;
    assign pc_update     = w_pc_update & rst_n;
    assign branch        = w_branch    & rst_n;
    assign ir_write      = w_ir_write  & rst_n;
    assign reg_write     = w_reg_write & rst_n;
    assign mem_write     = w_mem_write & rst_n;
    assign illegal_instr = r_illegal;
    assign state_o       = r_state;

    imm_src_decoder u_imm_src_decoder (
        .i_op      (op),
        .o_imm_src (imm_src)
    );

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: directed scenarios plus randomized
// instruction streams against an instruction-level reference model.
module tb_multicycle_main_fsm;
    import riscv_ctrl_pkg::*;

    localparam logic [6:0] T_LW = 7'b0000011, T_SW = 7'b0100011, T_R = 7'b0110011,
                           T_I = 7'b0010011, T_BEQ = 7'b1100011, T_JAL = 7'b1101111,
                           T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_v  [2];
    logic [6:0] op_v   [2];
    logic       rdy_v  [2];
    logic       t_mreq [2], t_pcu [2], t_br [2], t_irw [2], t_rw [2], t_mw [2], t_adr [2], t_ill [2];
    logic [1:0] t_sa [2], t_sb [2], t_rs [2], t_aop [2];
    logic [2:0] t_imm [2];
    logic [3:0] t_st [2];

    int n_tests = 0;
    int n_fail  = 0;
    int active  = -1;
    state_t seq[$];
    bit     seq_trap;

    always #5 clk = ~clk;

    multicycle_main_fsm #(.MEM_WAIT(1'b1), .EN_JALR(1'b1), .EN_UPPER(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_v[0]), .op(op_v[0]), .mem_ready(rdy_v[0]),
        .mem_req(t_mreq[0]), .pc_update(t_pcu[0]), .branch(t_br[0]), .ir_write(t_irw[0]),
        .reg_write(t_rw[0]), .mem_write(t_mw[0]), .adr_src(t_adr[0]), .alu_src_a(t_sa[0]),
        .alu_src_b(t_sb[0]), .result_src(t_rs[0]), .alu_op(t_aop[0]), .imm_src(t_imm[0]),
        .illegal_instr(t_ill[0]), .state_o(t_st[0]));

    multicycle_main_fsm #(.MEM_WAIT(1'b0), .EN_JALR(1'b0), .EN_UPPER(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_v[1]), .op(op_v[1]), .mem_ready(rdy_v[1]),
        .mem_req(t_mreq[1]), .pc_update(t_pcu[1]), .branch(t_br[1]), .ir_write(t_irw[1]),
        .reg_write(t_rw[1]), .mem_write(t_mw[1]), .adr_src(t_adr[1]), .alu_src_a(t_sa[1]),
        .alu_src_b(t_sb[1]), .result_src(t_rs[1]), .alu_op(t_aop[1]), .imm_src(t_imm[1]),
        .illegal_instr(t_ill[1]), .state_o(t_st[1]));

    function automatic bit cfg_wait(int d);  return d == 0; endfunction
    function automatic bit cfg_jalr(int d);  return d == 0; endfunction
    function automatic bit cfg_upper(int d); return d == 0; endfunction

    function automatic logic [15:0] obs(int d);
        return {t_mreq[d], t_pcu[d], t_br[d], t_irw[d], t_rw[d], t_mw[d], t_adr[d],
                t_sa[d], t_sb[d], t_rs[d], t_aop[d], t_ill[d]};
    endfunction

    function automatic logic [15:0] mk(logic mq, logic pu, logic b, logic iw, logic rw, logic mw,
                                       logic ad, logic [1:0] a, logic [1:0] bs, logic [1:0] rs,
                                       logic [1:0] ao, logic il);
        return {mq, pu, b, iw, rw, mw, ad, a, bs, rs, ao, il};
    endfunction

    // Control word each step of an instruction must present
    function automatic logic [15:0] exp_out(state_t st, logic r);
        case (st)
            S_FETCH:    return mk(1, r, 0, r, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
            S_DECODE:   return mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
            S_MEMADR:   return mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
            S_MEMREAD:  return mk(1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            S_MEMWB:    return mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
            S_MEMWRITE: return mk(1, 0, 0, 0, 0, r, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            S_EXECUTER: return mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0);
            S_EXECUTEI: return mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0);
            S_ALUWB:    return mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            S_BEQ:      return mk(0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
            S_JAL:      return mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0);
            S_JALR:     return mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
            S_JALR2:    return mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0);
            S_LUI:      return mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 0);
            S_AUIPC:    return mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
            default:    return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        endcase
    endfunction

    // FETCH selects with every enable held off
    localparam logic [15:0] RST_OUT = 16'b0000000_00_10_10_00_0;

    function automatic logic [2:0] exp_imm(logic [6:0] o);
        if (o == T_SW)  return 3'b001;
        if (o == T_BEQ) return 3'b010;
        if (o == T_JAL) return 3'b011;
        if (o == T_LUI || o == T_AUIPC) return 3'b100;
        return 3'b000;
    endfunction

    // Nominal cycles per instruction class (0 = illegal for this configuration)
    function automatic int cpi(logic [6:0] o, int d);
        case (o)
            T_LW:            return 5;
            T_SW, T_R, T_I:  return 4;
            T_BEQ:           return 3;
            T_JAL:           return 4;
            T_JALR:          return cfg_jalr(d) ? 5 : 0;
            T_LUI, T_AUIPC:  return cfg_upper(d) ? 4 : 0;
            default:         return 0;
        endcase
    endfunction

    // Step list an instruction walks through; illegal ones end in TRAP + 10 held cycles
    function automatic void build(logic [6:0] o, int d);
        seq.delete();
        seq_trap = 1'b0;
        seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (o)
            T_LW:  begin seq.push_back(S_MEMADR); seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
            T_SW:  begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWRITE); end
            T_R:   begin seq.push_back(S_EXECUTER); seq.push_back(S_ALUWB); end
            T_I:   begin seq.push_back(S_EXECUTEI); seq.push_back(S_ALUWB); end
            T_BEQ: seq.push_back(S_BEQ);
            T_JAL: begin seq.push_back(S_JAL); seq.push_back(S_ALUWB); end
            T_JALR:
                if (cfg_jalr(d)) begin seq.push_back(S_JALR); seq.push_back(S_JALR2); seq.push_back(S_ALUWB); end
                else seq_trap = 1'b1;
            T_LUI:
                if (cfg_upper(d)) begin seq.push_back(S_LUI); seq.push_back(S_ALUWB); end
                else seq_trap = 1'b1;
            T_AUIPC:
                if (cfg_upper(d)) begin seq.push_back(S_AUIPC); seq.push_back(S_ALUWB); end
                else seq_trap = 1'b1;
            default: seq_trap = 1'b1;
        endcase
        if (seq_trap)
            for (int k = 0; k < 11; k++) seq.push_back(S_TRAP);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs one instruction on dut d; rpat bit n is mem_ready for cycle n
    task automatic run_instr(int d, logic [6:0] o, logic [31:0] rpat, output int cyc);
        int idx = 0, stalls = 0, irc = 0, rwc = 0, mwc = 0;
        state_t st;
        logic r;
        cyc = 0;
        build(o, d);
        while (idx < seq.size() && cyc < 40) begin
            @(negedge clk);
            op_v[d]  = o;
            rdy_v[d] = rpat[cyc % 32];
            #1;
            st = seq[idx];
            r  = cfg_wait(d) ? rdy_v[d] : 1'b1;
            chk("state", {28'b0, t_st[d]}, {28'b0, st});
            chk("ctrl", {16'b0, obs(d)}, {16'b0, exp_out(st, r)});
            chk("imm_src", {29'b0, t_imm[d]}, {29'b0, exp_imm(o)});
            irc += int'(t_irw[d]);
            rwc += int'(t_rw[d]);
            mwc += int'(t_mw[d]);
            if ((st == S_FETCH || st == S_MEMREAD || st == S_MEMWRITE) && !r) stalls++;
            else idx++;
            cyc++;
        end
        chk("ir_write_once", irc, 1);
        chk("mem_write_count", mwc, (o == T_SW) ? 1 : 0);
        if (!seq_trap) begin
            chk("cycles", cyc, cpi(o, d) + stalls);
            chk("reg_write_count", rwc, (o == T_SW || o == T_BEQ) ? 0 : 1);
        end
    endtask

    task automatic reset_dut(int d);
        @(negedge clk);
        rst_v[d] = 1'b0;
        rdy_v[d] = 1'b1;
        #1;
        chk("rst_state", {28'b0, t_st[d]}, 32'd0);
        chk("rst_ctrl", {16'b0, obs(d)}, {16'b0, RST_OUT});
        @(posedge clk);
        #1 rst_v[d] = 1'b1;
    endtask

    // Parks the idle DUT in reset so it cannot wander while the other runs
    task automatic select_dut(int d);
        if (active != d) begin
            @(negedge clk);
            if (active >= 0) rst_v[active] = 1'b0;
            @(posedge clk);
            #1 rst_v[d] = 1'b1;
            active = d;
        end
    endtask

    logic [6:0] ops [9] = '{T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL, T_JALR, T_LUI, T_AUIPC};

    initial begin
        int cyc;
        int d;
        int k;
        logic [6:0] o;

        rst_v = '{1'b0, 1'b0};
        op_v  = '{7'd0, 7'd0};
        rdy_v = '{1'b1, 1'b1};
        #1;
        chk("init_state0", {28'b0, t_st[0]}, 32'd0);
        chk("init_ctrl0", {16'b0, obs(0)}, {16'b0, RST_OUT});
        chk("init_ctrl1", {16'b0, obs(1)}, {16'b0, RST_OUT});
        repeat (2) @(posedge clk);
        select_dut(0);

        // lw with two FETCH stalls and one MEMREAD stall
        run_instr(0, T_LW, 32'hFFFF_FFDC, cyc);
        chk("lw_stalled_cycles", cyc, 8);

        run_instr(0, T_R, 32'hFFFF_FFFF, cyc);
        run_instr(0, T_JALR, 32'hFFFF_FFFF, cyc);
        run_instr(0, T_LUI, 32'hFFFF_FFFF, cyc);
        run_instr(0, T_BEQ, 32'hFFFF_FFFF, cyc);

        // Undefined opcode traps and holds
        run_instr(0, 7'b1111111, 32'hFFFF_FFFF, cyc);
        chk("trap_flag", {31'b0, t_ill[0]}, 32'd1);
        reset_dut(0);
        chk("trap_cleared", {31'b0, t_ill[0]}, 32'd0);

        // Reset in the middle of a stalled MEMREAD
        @(negedge clk); op_v[0] = T_LW; rdy_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rdy_v[0] = 1'b0;
        #1 chk("pre_abort_state", {28'b0, t_st[0]}, 32'd3);
        @(negedge clk);
        rst_v[0] = 1'b0;
        rdy_v[0] = 1'b1;
        #1;
        chk("abort_state", {28'b0, t_st[0]}, 32'd0);
        chk("abort_ctrl", {16'b0, obs(0)}, {16'b0, RST_OUT});
        @(negedge clk);
        #1 chk("abort_hold_ctrl", {16'b0, obs(0)}, {16'b0, RST_OUT});
        @(posedge clk);
        #1 rst_v[0] = 1'b1;
        run_instr(0, T_I, 32'hFFFF_FFFF, cyc);

        // No-wait configuration: memory ready ignored, jalr/upper disabled
        select_dut(1);
        run_instr(1, T_SW, 32'h0000_0000, cyc);
        chk("sw_nowait_cycles", cyc, 4);
        run_instr(1, T_JALR, 32'h0000_0000, cyc);
        chk("jalr_disabled_flag", {31'b0, t_ill[1]}, 32'd1);
        reset_dut(1);

        // Randomized instruction stream on both configurations
        for (int n = 0; n < 60; n++) begin
            d = int'($urandom_range(0, 1));
            k = int'($urandom_range(0, 10));
            o = (k < 9) ? ops[k] : 7'($urandom_range(0, 127));
            select_dut(d);
            run_instr(d, o, $urandom | $urandom, cyc);
            if (seq_trap) reset_dut(d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
